// File: rtl/cla_subtractor_pipe.sv
// rtl/cla_subtractor_pipe.sv - two-stage pipelined carry-lookahead subtractor
// D = A + ~B + ~Bin; low half in stage 1, high half and flags in stage 2.
module cla_subtractor_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             V,
  output logic             Z
);

  localparam int H = WIDTH / 2;

  // Returns {carry_out, sum} of a + ~b + cin with every carry expanded as a
  // flat generate/propagate sum of products rather than a ripple chain.
  function automatic logic [H:0] cla_half(input logic [H-1:0] a,
                                          input logic [H-1:0] b,
                                          input logic         cin);
    logic [H-1:0] p, g;
    logic [H:0]   c;
    logic         acc, prod;
    p    = a ^ ~b;
    g    = a & ~b;
    c[0] = cin;
    for (int i = 0; i < H; i++) begin
      acc  = 1'b0;
      prod = 1'b1;
      for (int j = i; j >= 0; j--) begin
        acc  = acc | (prod & g[j]);
        prod = prod & p[j];
      end
      c[i+1] = acc | (prod & cin);
    end
    return {c[H], p ^ c[H-1:0]};
  endfunction

  logic         s1_valid;
  logic [H-1:0] s1_d_lo;
  logic         s1_c_mid;
  logic [H-1:0] s1_a_hi;
  logic [H-1:0] s1_b_hi;

  logic         s1_en, s2_en;
  logic [H:0]   lo_res, hi_res;
  logic [WIDTH-1:0] d_next;

  assign s2_en    = !out_valid || out_ready;
  assign s1_en    = !s1_valid || s2_en;
  assign in_ready = s1_en;

  assign lo_res = cla_half(A[H-1:0], B[H-1:0], ~Bin);
  assign hi_res = cla_half(s1_a_hi, s1_b_hi, s1_c_mid);
  assign d_next = {hi_res[H-1:0], s1_d_lo};

  // Data registers only move with a real beat so the operands are sampled
  // solely on accepting edges and an idle output keeps its last result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_d_lo  <= '0;
      s1_c_mid <= 1'b0;
      s1_a_hi  <= '0;
      s1_b_hi  <= '0;
    end else if (s1_en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_d_lo  <= lo_res[H-1:0];
        s1_c_mid <= lo_res[H];
        s1_a_hi  <= A[WIDTH-1:H];
        s1_b_hi  <= B[WIDTH-1:H];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      D         <= '0;
      Bout      <= 1'b0;
      V         <= 1'b0;
      Z         <= 1'b0;
    end else if (s2_en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        D    <= d_next;
        Bout <= ~hi_res[H];
        V    <= (s1_a_hi[H-1] ^ s1_b_hi[H-1]) & (hi_res[H-1] ^ s1_a_hi[H-1]);
        Z    <= (d_next == '0);
      end
    end
  end

endmodule

// File: doc/cla_subtractor_pipe.md
# cla_subtractor_pipe

Two-stage pipelined WIDTH-bit subtractor with a valid/ready handshake on both sides. It computes D = A − B − Bin as A + ~B + ~Bin, using per-bit propagate/generate and carry-lookahead carries, and returns borrow, signed-overflow and zero flags. It is the inverse-direction companion of the team's 16-bit carry-lookahead adder and sits in the datapath wherever a registered, back-pressurable difference is needed (compare, decrement, address delta).

## Interface
- WIDTH, 16: operand width; must be even and ≥ 4. Stage 1 handles bits [WIDTH/2−1:0], stage 2 handles the upper half.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand beat is present.
- in_ready  out  1  block accepts a beat this cycle; combinational.
- A  in  WIDTH  minuend.
- B  in  WIDTH  subtrahend.
- Bin  in  1  borrow in.
- out_valid  out  1  result beat is present.
- out_ready  in  1  consumer accepts the result.
- D  out  WIDTH  difference, modulo 2^WIDTH.
- Bout  out  1  borrow out; 1 iff A < B + Bin (unsigned).
- V  out  1  signed overflow of A − B − Bin.
- Z  out  1  D == 0.

## Operation
- Per bit: p = A ^ ~B, g = A & ~B. Carries use c[i+1] = g | (p & c), with c[0] = ~Bin. Sum bit = p ^ c.
- Stage 1 (register s1) captures:
  - D_lo, the low half of the sum;
  - c_mid, the carry out of the low half;
  - A_hi and B_hi;
  - s1_valid.
- Stage 2 (output registers):
  - D = {hi_sum, D_lo}, where the upper half uses carry-in c_mid.
  - Bout = ~c[WIDTH].
  - V = (A[MSB] ^ B[MSB]) & (D[MSB] ^ A[MSB]).
  - Z = (D == 0).
- Handshake enables:
  - s2_en = !out_valid | out_ready.
  - s1_en = !s1_valid | s2_en.
  - in_ready = s1_en.
- Transfers:
  - Input accepted when in_valid & in_ready.
  - s1 loads the incoming beat when s1_en. s1_valid ← in_valid & in_ready.
  - Output registers load from s1 when s2_en. out_valid ← s1_valid.
- When out_valid & !out_ready, D, Bout, V and Z hold stable. s1 then holds if it is valid.
- Ordering is strictly FIFO. No beat is dropped or duplicated. Capacity is 2 beats.
- Unsigned (Bout) and signed (V) interpretations are both always produced. The consumer selects which to use.

## Timing
- Reset values: s1_valid = 0, out_valid = 0, D = 0, Bout = 0, V = 0, Z = 0, all s1 data = 0. in_ready = 1 while rst is deasserted and the pipe is empty.
- Latency: a beat accepted at edge n appears with out_valid = 1 after edge n+1, provided out_ready was not stalling. Minimum latency is 2 cycles from the in_valid cycle.
- Throughput: 1 beat per cycle while out_ready = 1.
- Full pipe (s1_valid & out_valid & !out_ready): in_ready = 0.
- Simultaneous output pop and input push while full: both occur in the same cycle, and the pipe stays full.
- When rst asserts mid-stream, all in-flight beats are discarded immediately (asynchronous), and outputs go to their reset values. The first accept after reset deasserts occurs on the first rising edge with in_valid = 1.
- A, B and Bin are sampled only on an accepting edge. Changing them while not accepted has no effect.
- No combinational path from A, B or Bin to any output. The only combinational path is out_ready → in_ready.

## Test plan
- Basic subtract: A=0x1234, B=0x0234, Bin=0 with out_ready=1. Required: out_valid two cycles later with D=0x1000, Bout=0, V=0, Z=0.
- Borrow across halves: A=0x0100, B=0x0001. Required: D=0x00FF, Bout=0. Then A=0x0000, B=0x0001. Required: D=0xFFFF, Bout=1, V=0.
- Signed overflow: A=0x8000, B=0x0001. Required: D=0x7FFF, V=1, Bout=0. Then A=0x7FFF, B=0xFFFF. Required: D=0x8000, V=1, Bout=1.
- Zero and borrow-in: A=0x00FF, B=0x00FF, Bin=0. Required: D=0x0000, Z=1, Bout=0. Same operands with Bin=1. Required: D=0xFFFF, Z=0, Bout=1.
- Backpressure: drive 4 back-to-back beats (A=1..4, B=0) with out_ready=0 for 3 cycles, then 1. Required: in_ready=0 after 2 beats are accepted, D held at 1 while stalled, then results 1, 2, 3, 4 in order with none lost.
- Reset mid-stream: assert rst for 1 cycle while 2 beats are in flight. Required: out_valid=0 and D=0 immediately, in_ready=1 after release, and the next beat (A=5, B=2) yields D=3 two cycles after it is accepted.
